// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared FSM encoding, size/rw constants and timeout limit
package mem_access_unit_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam logic [7:0] TIMEOUT_MAX = 8'd255;
  typedef struct packed {
    logic        size;
    logic        rw;
    logic        load;
    logic        rf;
    logic [3:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;
endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: byte-enable generation, store byte replication and load lane extraction
module mem_byte_lane
  import mem_access_unit_pkg::*;
(
  input  logic        size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic byte_op;
  always_comb begin
    byte_op = size_i == SIZE_BYTE;
    byte_en_o = byte_op ? 4'b0001 << lane_i : 4'b1111;
    wdata_o = byte_op ? {4{wdata_i[7:0]}} : wdata_i;
    rdata_o = byte_op ? {24'd0, rdata_i[{lane_i, 3'b000} +: 8]} : rdata_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage access FSM with wait timeout; MEM_ALIGN_CHECK_EN rejects misaligned word ops
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        Size_In,
  input  logic        Enable_In,
  input  logic        rw_In,
  input  logic        Load_In,
  input  logic        rf_In,
  input  logic [31:0] Addr_In,
  input  logic [31:0] Data_In,
  input  logic [3:0]  Rd_In,
  output logic        Mem_Req,
  output logic        Mem_Write,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [3:0]  Mem_ByteEn,
  input  logic        Mem_Ready,
  input  logic [31:0] Mem_RData,
  output logic [31:0] Result_Out,
  output logic [3:0]  Rd_Out,
  output logic        rf_Out,
  output logic        Load_Out,
  output logic        Stall_Out,
  output logic        Err_Out
);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  req_t req_q, req_d;
  logic [31:0] result_q, result_d;
  logic [3:0] rd_q, rd_d;
  logic rf_q, rf_d, load_q, load_d, err_q, err_d;
  logic misalign, acc;
  logic [3:0] lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  mem_byte_lane u_lane (
    .size_i(req_q.size),
    .lane_i(req_q.addr[1:0]),
    .wdata_i(req_q.data),
    .rdata_i(Mem_RData),
    .byte_en_o(lane_be),
    .wdata_o(lane_wdata),
    .rdata_o(lane_rdata)
  );
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = Enable_In && Size_In == SIZE_WORD && Addr_In[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  assign acc = state_q == ACCESS;
  assign Mem_Req = acc;
  assign Mem_Write = acc && req_q.rw == RW_WRITE;
  assign Mem_Addr = !acc ? '0 : req_q.size == SIZE_WORD ? {req_q.addr[31:2], 2'b00} : req_q.addr;
  assign Mem_WData = acc ? lane_wdata : '0;
  assign Mem_ByteEn = acc ? lane_be : '0;
  assign Result_Out = result_q;
  assign Rd_Out = rd_q;
  assign rf_Out = rf_q;
  assign Load_Out = load_q;
  assign Err_Out = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    result_d = result_q;
    rd_d = rd_q;
    rf_d = rf_q;
    load_d = load_q;
    err_d = 1'b0;
    Stall_Out = 1'b0;
    case (state_q)
      IDLE: begin
        if (Enable_In && !misalign) begin
          req_d = '{size: Size_In, rw: rw_In, load: Load_In, rf: rf_In, rd: Rd_In, addr: Addr_In, data: Data_In};
          cnt_d = '0;
          state_d = ACCESS;
          Stall_Out = 1'b1;
        end else begin
          result_d = misalign ? '0 : Addr_In;
          rd_d = Rd_In;
          rf_d = rf_In && !misalign;
          load_d = Load_In;
          err_d = misalign;
        end
      end
      ACCESS: begin
        Stall_Out = 1'b1;
        if (Mem_Ready || cnt_q == TIMEOUT_MAX - 8'd1) begin
          result_d = !Mem_Ready ? '0 : req_q.rw == RW_READ ? lane_rdata : req_q.addr;
          rd_d = req_q.rd;
          rf_d = req_q.rf && Mem_Ready;
          load_d = req_q.load;
          err_d = !Mem_Ready;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_q <= '0;
      result_q <= '0;
      rd_q <= '0;
      rf_q <= 1'b0;
      load_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      result_q <= result_d;
      rd_q <= rd_d;
      rf_q <= rf_d;
      load_q <= load_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench with memory responder and reference model
module tb_mem_access_unit;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif
  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        rf;
    logic        load;
    logic        err;
    logic        req;
    int          stalls;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic        mwr;
  } exp_t;
  logic CLK, CLR, Size_In, Enable_In, rw_In, Load_In, rf_In;
  logic [31:0] Addr_In, Data_In;
  logic [3:0] Rd_In;
  logic Mem_Req, Mem_Write, Mem_Ready;
  logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
  logic [3:0] Mem_ByteEn;
  logic [31:0] Result_Out;
  logic [3:0] Rd_Out;
  logic rf_Out, Load_Out, Stall_Out, Err_Out;
  int vecs = 0;
  int errs = 0;
  int wait_n = 0;
  int acc_cnt = 0;
  int stall_cnt = 0;
  logic mon_en = 1'b0;
  logic drv_plain = 1'b0;
  logic stall_prev = 1'b0;
  logic plain_prev = 1'b0;
  logic req_seen = 1'b0;
  logic present;
  exp_t me;
  exp_t q[$];
  mem_access_unit dut (
    .CLK(CLK), .CLR(CLR), .Size_In(Size_In), .Enable_In(Enable_In), .rw_In(rw_In),
    .Load_In(Load_In), .rf_In(rf_In), .Addr_In(Addr_In), .Data_In(Data_In), .Rd_In(Rd_In),
    .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_ByteEn(Mem_ByteEn), .Mem_Ready(Mem_Ready), .Mem_RData(Mem_RData),
    .Result_Out(Result_Out), .Rd_Out(Rd_Out), .rf_Out(rf_Out), .Load_Out(Load_Out),
    .Stall_Out(Stall_Out), .Err_Out(Err_Out)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask
  function automatic exp_t model(input logic en, sz, rw, ld, rf, input logic [31:0] addr, data,
                                 input logic [3:0] rd, input int wn, input logic [31:0] rdat);
    exp_t e;
    int lane;
    lane = int'(addr[1:0]);
    e = '{res: 0, rd: rd, rf: 0, load: ld, err: 0, req: 0, stalls: 0, maddr: 0, mwdata: 0, mbe: 0, mwr: 0};
    if (!en) begin
      e.res = addr;
      e.rf = rf;
    end else if (ALIGN_CHK && sz && lane != 0) begin
      e.err = 1'b1;
    end else begin
      e.req = 1'b1;
      e.maddr = sz ? addr - 32'(lane) : addr;
      e.mbe = sz ? 4'hF : 4'(1 << lane);
      e.mwdata = sz ? data : 32'h01010101 * {24'd0, data[7:0]};
      e.mwr = rw;
      if (wn >= 255) begin
        e.err = 1'b1;
        e.stalls = 256;
      end else begin
        e.res = rw ? addr : sz ? rdat : (rdat >> (8 * lane)) % 256;
        e.rf = rf;
        e.stalls = wn + 2;
      end
    end
    return e;
  endfunction
  task automatic garbage();
    Enable_In = 1'($urandom);
    Size_In = 1'($urandom);
    rw_In = 1'($urandom);
    Load_In = 1'($urandom);
    rf_In = 1'($urandom);
    Addr_In = $urandom;
    Data_In = $urandom;
    Rd_In = 4'($urandom);
  endtask
  task automatic issue(input logic en, sz, rw, ld, rf, input logic [31:0] addr, data,
                       input logic [3:0] rd, input int wn, input logic [31:0] rdat);
    exp_t e;
    bit done;
    @(posedge CLK);
    #1;
    Enable_In = en;
    Size_In = sz;
    rw_In = rw;
    Load_In = ld;
    rf_In = rf;
    Addr_In = addr;
    Data_In = data;
    Rd_In = rd;
    wait_n = wn;
    Mem_RData = rdat;
    e = model(en, sz, rw, ld, rf, addr, data, rd, wn, rdat);
    q.push_back(e);
    drv_plain = !e.req;
    if (e.req) begin
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
        @(posedge CLK);
        #1;
        garbage();
        drv_plain = 1'b0;
        #1;
        done = !Stall_Out;
      end
      if (!done) begin
        vecs++;
        errs++;
        $display("FAIL stall_release: Stall_Out still 1 after 300 cycles, want 0");
      end
    end
  endtask
  initial begin
    Mem_Ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (Mem_Req) begin
        Mem_Ready = acc_cnt == wait_n;
        acc_cnt++;
      end else begin
        Mem_Ready = 1'b0;
        acc_cnt = 0;
      end
    end
  end
  initial forever begin
    @(negedge CLK);
    if (mon_en) begin
      present = (stall_prev && !Stall_Out) || plain_prev;
      if (present) begin
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_output: result %h with empty scoreboard", Result_Out);
        end else begin
          me = q.pop_front();
          chk("result", Result_Out, me.res);
          chk("rd", 32'(Rd_Out), 32'(me.rd));
          chk("rf", 32'(rf_Out), 32'(me.rf));
          chk("load", 32'(Load_Out), 32'(me.load));
          chk("err", 32'(Err_Out), 32'(me.err));
          chk("stall_cycles", 32'(stall_cnt), 32'(me.stalls));
          chk("req_seen", 32'(req_seen), 32'(me.req));
        end
        stall_cnt = 0;
        req_seen = 1'b0;
      end else begin
        chk("err_spurious", 32'(Err_Out), 32'd0);
      end
      if (Mem_Req) begin
        req_seen = 1'b1;
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_req: Mem_Req 1 with empty scoreboard, want 0");
        end else begin
          chk("mem_addr", Mem_Addr, q[0].maddr);
          chk("mem_wdata", Mem_WData, q[0].mwdata);
          chk("mem_byteen", 32'(Mem_ByteEn), 32'(q[0].mbe));
          chk("mem_write", 32'(Mem_Write), 32'(q[0].mwr));
        end
      end
      if (Stall_Out) stall_cnt++;
      stall_prev = Stall_Out;
      plain_prev = drv_plain;
    end
  end
  initial begin
    CLR = 1'b1;
    garbage();
    Enable_In = 1'b0;
    Addr_In = 32'hFFFF_FFFF;
    Rd_In = 4'hF;
    rf_In = 1'b1;
    Load_In = 1'b1;
    Mem_RData = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_result", Result_Out, 32'd0);
    chk("rst_rd", 32'(Rd_Out), 32'd0);
    chk("rst_rf", 32'(rf_Out), 32'd0);
    chk("rst_load", 32'(Load_Out), 32'd0);
    chk("rst_err", 32'(Err_Out), 32'd0);
    chk("rst_req", 32'(Mem_Req), 32'd0);
    chk("rst_write", 32'(Mem_Write), 32'd0);
    chk("rst_byteen", 32'(Mem_ByteEn), 32'd0);
    chk("rst_stall", 32'(Stall_Out), 32'd0);
    CLR = 1'b0;
    mon_en = 1'b1;
    issue(0, 0, 0, 0, 1, 32'h0000_1234, 32'h0, 4'd5, 0, 32'h0);
    issue(1, 1, 0, 1, 1, 32'h0000_0100, 32'h0, 4'd2, 1, 32'hDEAD_BEEF);
    issue(1, 0, 1, 0, 0, 32'h0000_0203, 32'h0000_00A5, 4'd0, 0, 32'h0);
    issue(1, 0, 0, 1, 1, 32'h0000_0202, 32'h0, 4'd7, 2, 32'h1122_3344);
    issue(1, 1, 0, 1, 1, 32'h0000_0300, 32'h0, 4'd9, 300, 32'hCAFE_F00D);
    issue(1, 1, 0, 1, 1, 32'h0000_0304, 32'h0, 4'd10, 254, 32'h0BAD_F00D);
    issue(1, 1, 0, 1, 1, 32'h0000_0102, 32'h0, 4'd11, 0, 32'h1234_5678);
    issue(0, 1, 1, 1, 0, 32'h0000_0050, 32'h0, 4'd12, 0, 32'h0);
    for (int n = 0; n < 300; n++) begin
      int r, wn;
      r = $urandom_range(0, 19);
      wn = r == 0 ? 300 : r == 1 ? 254 : $urandom_range(0, 4);
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, 4'($urandom), wn, $urandom);
    end
    @(posedge CLK);
    #1;
    Enable_In = 1'b0;
    drv_plain = 1'b0;
    repeat (3) @(negedge CLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    @(posedge CLK);
    #1;
    Enable_In = 1'b1;
    Size_In = 1'b1;
    rw_In = 1'b0;
    Addr_In = 32'h0000_0400;
    wait_n = 300;
    @(posedge CLK);
    #1;
    Enable_In = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("req_before_clr", 32'(Mem_Req), 32'd1);
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    Addr_In = 32'h0000_55AA;
    Rd_In = 4'd3;
    rf_In = 1'b1;
    Load_In = 1'b0;
    @(negedge CLK);
    chk("clr_req", 32'(Mem_Req), 32'd0);
    chk("clr_err", 32'(Err_Out), 32'd0);
    chk("clr_stall", 32'(Stall_Out), 32'd0);
    chk("clr_result", Result_Out, 32'd0);
    @(negedge CLK);
    chk("post_clr_result", Result_Out, 32'h0000_55AA);
    chk("post_clr_rd", 32'(Rd_Out), 32'd3);
    chk("post_clr_err", 32'(Err_Out), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
